// File: rtl/clock_pkg.sv
// Shared mode codes, button bit positions and arbiter state encoding for the clock front panel.
// Pure declarations, so it adds no latency and carries no flow control.
package clock_pkg;

  localparam logic [1:0] MODE_CLOCK = 2'd0;
  localparam logic [1:0] MODE_SW    = 2'd1;
  localparam logic [1:0] MODE_TMR   = 2'd2;
  localparam logic [1:0] MODE_ALM   = 2'd3;

  localparam int BTN_SET   = 4;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_ALERT  = 1'b1
  } arb_state_t;

  // Only the two alert sources ever reach this, so the "other" one is the opposite code.
  function automatic logic [1:0] other_src(input logic [1:0] src);
    return (src == MODE_ALM) ? MODE_TMR : MODE_ALM;
  endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter stepped by tick pulses, saturating at zero; load wins over tick.
// Flags are one-cycle: zero is registered, zero_next flags the tick that reaches zero; no backpressure.
module tick_down_counter #(
  parameter int MAX = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic zero,
  output logic zero_next
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(MAX);
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero      = (cnt == '0);
  // Independent of load so callers may reload on this flag without a combinational loop.
  assign zero_next = tick && (cnt == W'(1));

endmodule

// File: rtl/clock_mode_arbiter.sv
// Routes front-panel buttons to the selected function and preempts for timer/alarm alerts; o_btn_* are zero-latency, o_sel/o_alerting/o_buzz are registered.
// No backpressure: every pulse is consumed or dropped in its cycle. CLOCK_MODE_ARBITER_BUZZ_PULSE_EN selects a pulsed buzzer.
module clock_mode_arbiter
  import clock_pkg::*;
#(
  parameter int ALERT_TICKS = 10000,
  parameter int BUZZ_HALF   = 250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_1ms,
  input  logic       i_mode,
  input  logic [4:0] i_btn,
  input  logic [3:0] i_lock,
  input  logic       i_timer_done,
  input  logic       i_alarm_hit,
  output logic [1:0] o_sel,
  output logic [4:0] o_btn_clk,
  output logic [4:0] o_btn_sw,
  output logic [4:0] o_btn_tmr,
  output logic [4:0] o_btn_alm,
  output logic       o_buzz,
  output logic       o_alerting
);

  arb_state_t state, state_nx;
  logic [1:0] sel, sel_nx, saved, saved_nx;
  logic       pend, pend_nx, pend_lat;
  logic       ack, cur_hit, oth_hit, expire;
  logic       tmo_load, tmo_tick, tmo_zero, tmo_zero_next;

  assign ack      = |i_btn;
  assign cur_hit  = (sel == MODE_ALM) ? i_alarm_hit : i_timer_done;
  assign oth_hit  = (sel == MODE_ALM) ? i_timer_done : i_alarm_hit;
  assign pend_lat = pend | oth_hit;
  assign tmo_tick = (state == ST_ALERT) && i_tick_1ms;
  assign expire   = tmo_zero_next || (tmo_tick && tmo_zero);

  tick_down_counter #(.MAX(ALERT_TICKS)) u_timeout (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (tmo_load),
    .tick      (tmo_tick),
    .zero      (tmo_zero),
    .zero_next (tmo_zero_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_NORMAL;
      sel   <= MODE_CLOCK;
      saved <= MODE_CLOCK;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      saved <= saved_nx;
      pend  <= pend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    saved_nx = saved;
    pend_nx  = pend;
    tmo_load = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (i_alarm_hit || i_timer_done) begin
          state_nx = ST_ALERT;
          saved_nx = sel;
          sel_nx   = i_alarm_hit ? MODE_ALM : MODE_TMR;
          pend_nx  = i_alarm_hit && i_timer_done;
          tmo_load = 1'b1;
        end else if (i_mode && !i_lock[sel]) begin
          sel_nx = sel + 2'd1;
        end
      end
      ST_ALERT: begin
        // A repeat from the current source re-arms the timeout instead of letting it expire.
        if (ack || (expire && !cur_hit)) begin
          pend_nx = 1'b0;
          if (pend_lat) begin
            sel_nx   = other_src(sel);
            tmo_load = 1'b1;
          end else begin
            state_nx = ST_NORMAL;
            sel_nx   = saved;
          end
        end else begin
          pend_nx  = pend_lat;
          tmo_load = cur_hit;
        end
      end
      default: state_nx = ST_NORMAL;
    endcase
  end

  always_comb begin
    o_btn_clk = '0;
    o_btn_sw  = '0;
    o_btn_tmr = '0;
    o_btn_alm = '0;
    if (state == ST_NORMAL) begin
      case (sel)
        MODE_CLOCK: o_btn_clk = i_btn;
        MODE_SW:    o_btn_sw  = i_btn;
        MODE_TMR:   o_btn_tmr = i_btn;
        default:    o_btn_alm = i_btn;
      endcase
    end
  end

  assign o_sel      = sel;
  assign o_alerting = (state == ST_ALERT);

`ifdef CLOCK_MODE_ARBITER_BUZZ_PULSE_EN
  logic buzz, ph_load, ph_zero, ph_zero_next, ph_toggle, restart;

  assign restart   = (state_nx == ST_ALERT) && ((state == ST_NORMAL) || (sel_nx != sel));
  assign ph_toggle = ph_zero_next || (tmo_tick && ph_zero);
  assign ph_load   = restart || ph_toggle;

  tick_down_counter #(.MAX(BUZZ_HALF)) u_phase (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (ph_load),
    .tick      (tmo_tick),
    .zero      (ph_zero),
    .zero_next (ph_zero_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || (state_nx == ST_NORMAL)) begin
      buzz <= 1'b0;
    end else if (restart) begin
      buzz <= 1'b1;
    end else if (ph_toggle) begin
      buzz <= ~buzz;
    end
  end

  assign o_buzz = buzz;
`else
  assign o_buzz = o_alerting;
`endif

endmodule
